// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register driving register-file writeback, forwarding tap and retire pulse.
// Latency: 1 cycle from MEM inputs to wb_* outputs; stall holds the register, flush kills the captured slot.
// Backpressure: stall freezes state and a done flag limits each instruction to one write; WB_RETIRE_CNT_EN adds a retired counter.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [RN_W-1:0]   mem_rn,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_mdo,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_wreg,
    output logic [RN_W-1:0]   wb_rn,
    output logic [DATA_W-1:0] wdi,
    output logic              fwd_hit,
    output logic              retire,
    output logic [31:0]       retired
);

    logic              v_q;
    logic              wreg_q;
    logic              m2reg_q;
    logic [RN_W-1:0]   rn_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdo_q;
    logic              done_q;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            v_q     <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            rn_q    <= '0;
            alu_q   <= '0;
            mdo_q   <= '0;
            done_q  <= 1'b0;
        end else if (!stall) begin
            v_q     <= mem_valid & ~flush;
            wreg_q  <= mem_wreg;
            m2reg_q <= mem_m2reg;
            rn_q    <= mem_rn;
            alu_q   <= mem_alu;
            mdo_q   <= mem_mdo;
            done_q  <= 1'b0;
        end else begin
            // Held instruction has already had its write cycle once done is set.
            if (v_q) begin
                done_q <= 1'b1;
            end
            if (flush) begin
                v_q <= 1'b0;
            end
        end
    end

    logic rn_nz;
    assign rn_nz   = (rn_q != '0);
    assign wdi     = m2reg_q ? mdo_q : alu_q;
    assign wb_rn   = rn_q;
    assign fwd_hit = v_q & wreg_q & rn_nz;
    assign wb_wreg = fwd_hit & ~done_q;
    assign retire  = v_q & ~done_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_cnt;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    assign retired = retired_cnt;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table-driven single-cycle vectors through a scoreboard queue, plus reset and counter-wrap sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mem_valid, mem_wreg, mem_m2reg, stall, flush;
    logic [4:0]  mem_rn;
    logic [31:0] mem_alu, mem_mdo;
    logic        wb_wreg, fwd_hit, retire;
    logic [4:0]  wb_rn;
    logic [31:0] wdi, retired;

    wb_stage #(.DATA_W(32), .RN_W(5)) dut (
        .clk(clk), .clrn(clrn),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_rn(mem_rn), .mem_alu(mem_alu), .mem_mdo(mem_mdo),
        .stall(stall), .flush(flush),
        .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wdi(wdi),
        .fwd_hit(fwd_hit), .retire(retire), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, wreg, m2, st, fl;
        logic [4:0]  rn;
        logic [31:0] alu, mdo;
        logic        e_wreg;
        logic [4:0]  e_rn;
        logic [31:0] e_wdi;
        logic        e_fwd, e_ret;
    } vec_t;

    typedef struct {
        logic        wreg;
        logic [4:0]  rn;
        logic [31:0] wdi;
        logic        fwd, ret;
    } out_t;

    out_t        exp_q[$];
    vec_t        vecs[14];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        prev_ret = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] cnt_expect();
`ifdef WB_RETIRE_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // Drive one vector at the falling edge, clock it in, compare the popped expectation after the edge.
    task automatic run_vec(input vec_t t, input string name);
        out_t e;
        @(negedge clk);
        mem_valid = t.v; mem_wreg = t.wreg; mem_m2reg = t.m2; mem_rn = t.rn;
        mem_alu = t.alu; mem_mdo = t.mdo; stall = t.st; flush = t.fl;
        exp_q.push_back('{wreg: t.e_wreg, rn: t.e_rn, wdi: t.e_wdi, fwd: t.e_fwd, ret: t.e_ret});
        @(posedge clk);
        #1;
        exp_cnt  = exp_cnt + {31'd0, prev_ret};
        prev_ret = t.e_ret;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, ".wb_wreg"}, {31'd0, wb_wreg}, {31'd0, e.wreg});
            check({name, ".wb_rn"},   {27'd0, wb_rn},   {27'd0, e.rn});
            check({name, ".wdi"},     wdi,              e.wdi);
            check({name, ".fwd_hit"}, {31'd0, fwd_hit}, {31'd0, e.fwd});
            check({name, ".retire"},  {31'd0, retire},  {31'd0, e.ret});
            check({name, ".retired"}, retired,          cnt_expect());
        end
    endtask

    task automatic check_zero(input string name);
        check({name, ".wb_wreg"}, {31'd0, wb_wreg}, 32'd0);
        check({name, ".wb_rn"},   {27'd0, wb_rn},   32'd0);
        check({name, ".wdi"},     wdi,              32'd0);
        check({name, ".fwd_hit"}, {31'd0, fwd_hit}, 32'd0);
        check({name, ".retire"},  {31'd0, retire},  32'd0);
        check({name, ".retired"}, retired,          32'd0);
    endtask

    initial begin
        //            v     wreg  m2    st    fl    rn      alu            mdo            e_wreg e_rn   e_wdi          e_fwd e_ret
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0000_1234, 32'h0,         1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9,  32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0055, 32'h0,         1'b0, 5'd0,  32'h0000_0055, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0077, 32'h0,         1'b0, 5'd3,  32'h0000_0077, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6,  32'h0000_0099, 32'h0,         1'b0, 5'd6,  32'h0000_0099, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8,  32'h0,         32'h0000_00AA, 1'b0, 5'd8,  32'h0000_00AA, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0700, 32'h0,         1'b1, 5'd7,  32'h0000_0700, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 5'd7,  32'h0000_0700, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 5'd7,  32'h0000_0700, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0000_00A0, 32'h0,         1'b1, 5'd10, 32'h0000_00A0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'h0000_00B0, 32'h0,         1'b1, 5'd11, 32'h0000_00B0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_00C0, 32'h0,         1'b0, 5'd11, 32'h0000_00B0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};

        clrn = 1'b1;
        mem_valid = 1'b1; mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd3;
        mem_alu = 32'h1111_1111; mem_mdo = 32'h2222_2222; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        clrn = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset arriving while an instruction is held by stall.
        run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0000_00D0, 32'h0, 1'b1, 5'd13, 32'h0000_00D0, 1'b1, 1'b1}, "rst_cap");
        run_vec('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd14, 32'h0000_00E0, 32'h0, 1'b0, 5'd13, 32'h0000_00D0, 1'b1, 1'b0}, "rst_stall");
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check_zero("rst_mid");
        exp_cnt  = 32'd0;
        prev_ret = 1'b0;
        @(posedge clk);
        run_vec('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd14, 32'h0000_00E0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}, "rst_rel");
        clrn = 1'b0;
        run_vec('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd14, 32'h0000_00E0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}, "post_rst_hold");
        run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15, 32'h0000_00F0, 32'h0, 1'b1, 5'd15, 32'h0000_00F0, 1'b1, 1'b1}, "post_rst_cap");

`ifdef WB_RETIRE_CNT_EN
        // Preload the counter just below wrap; the pending retirement rolls it to zero.
        @(negedge clk);
        force dut.retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        run_vec('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0002, 32'h0, 1'b0, 5'd2, 32'h0000_0002, 1'b0, 1'b1}, "wrap");
        check("wrap_zero", retired, 32'd0);
        run_vec('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}, "wrap_next");
`endif

        run_vec('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}, "drain");
        check("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters: DATA_W, 32, datapath/writeback data width; RN_W, 5, register-number width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 clrn  input  1  asynchronous, active-high reset (high = reset).
REQ-004 mem_valid  input  1  MEM stage presents an instruction this cycle.
REQ-005 mem_wreg  input  1  instruction writes the register file.
REQ-006 mem_m2reg  input  1  1 = write data from memory, 0 = from ALU.
REQ-007 mem_rn  input  RN_W  destination register number.
REQ-008 mem_alu  input  DATA_W  ALU result.
REQ-009 mem_mdo  input  DATA_W  memory read data.
REQ-010 stall  input  1  hold the MEM/WB register.
REQ-011 flush  input  1  kill the instruction being captured.
REQ-012 wb_wreg  output  1  register-file write enable to ID stage.
REQ-013 wb_rn  output  RN_W  register-file write address to ID stage.
REQ-014 wdi  output  DATA_W  register-file write data to ID stage.
REQ-015 fwd_hit  output  1  bypass valid for EX/ID forwarding.
REQ-016 retire  output  1  one-cycle pulse per retired instruction.
REQ-017 retired  output  32  retired-instruction count (see Configuration).

Function
REQ-018 The block SHALL hold the MEM/WB register {v, wreg, m2reg, rn, alu, mdo}, loaded on each rising clk edge when stall=0.
REQ-019 The capture rule SHALL be: v <= mem_valid & ~flush; all other fields SHALL load regardless of v.
REQ-020 While stall=1, the register SHALL hold; flush with stall=1 SHALL clear v and leave the other fields unchanged.
REQ-021 wdi SHALL be combinational: mdo when m2reg=1, else alu.
REQ-022 wb_rn SHALL equal the registered rn.
REQ-023 wb_wreg SHALL equal v & wreg & (rn != 0) & ~done.
REQ-024 done SHALL be a 1-bit flag: set when v=1 and stall=1; cleared on any non-stalled clock edge.
REQ-025 As a result, a stalled instruction SHALL write exactly once, in its first WB cycle.
REQ-026 fwd_hit SHALL equal v & wreg & (rn != 0), independent of done, so forwarding stays valid during a stall.
REQ-027 retire SHALL equal v & ~done, so it is high exactly one cycle per valid instruction, including instructions with wreg=0.
REQ-028 Latency SHALL be 1 cycle: MEM inputs at edge N appear on the wb_* outputs after edge N.
REQ-029 A write to r0 SHALL never be issued; the data path is unaffected.

Reset
REQ-030 With clrn=1, the block SHALL asynchronously clear v, wreg, m2reg, rn, alu, mdo, done and retired to 0.
REQ-031 While clrn=1: wb_wreg=0, wb_rn=0, wdi=0, fwd_hit=0, retire=0.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction; no write occurs after release.
REQ-033 On the first edge after release, the block SHALL capture normally.

Configuration
REQ-034 With WB_RETIRE_CNT_EN defined, retired SHALL increment by 1 (mod 2^32, wrapping 0xFFFFFFFF -> 0) on each edge where retire=1.
REQ-035 Without WB_RETIRE_CNT_EN, retired SHALL be tied to 0, no counter flops SHALL be instantiated, and retire SHALL still function.

Verification
REQ-036 ALU write: mem_valid=1, wreg=1, m2reg=0, rn=5, alu=0x1234 -> next cycle wb_wreg=1, wb_rn=5, wdi=0x1234, retire=1.
REQ-037 Load: m2reg=1, mdo=0xDEADBEEF, alu=0x40, rn=9 -> wdi=0xDEADBEEF, wb_rn=9.
REQ-038 r0 suppression: rn=0, wreg=1 -> wb_wreg=0, fwd_hit=0, retire=1.
REQ-039 Stall 3 cycles with rn=7 captured -> wb_wreg high in cycle 1 only, fwd_hit high all 3 cycles, retire pulses once, retired +1.
REQ-040 Flush with mem_valid=1 -> next cycle wb_wreg=0, retire=0, retired unchanged.
REQ-041 Counter wrap (macro on): preload to 0xFFFFFFFF via 0xFFFFFFFF retirements, or force in sim -> one retirement -> retired=0; clrn pulse mid-stall -> all outputs 0 and no later write.
